// File: rtl/axi_rd_resp_slave.sv
// AXI4 read-channel slave acting as a DDR stand-in: one outstanding AR, programmable
// first-beat latency, FIXED/INCR/WRAP beat addressing and address-derived read data.
module axi_rd_resp_slave #(
  parameter int ID_W       = 1,
  parameter int ADDR_W     = 32,
  parameter int USER_W     = 8,
  parameter int RD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic [ID_W-1:0]   S_AXI_ARID,
  input  logic [ADDR_W-1:0] S_AXI_ARADDR,
  input  logic [7:0]        S_AXI_ARLEN,
  input  logic [2:0]        S_AXI_ARSIZE,
  input  logic [1:0]        S_AXI_ARBURST,
  input  logic [USER_W-1:0] S_AXI_ARUSER,
  input  logic              S_AXI_ARVALID,
  output logic              S_AXI_ARREADY,
  output logic [ID_W-1:0]   S_AXI_RID,
  output logic [63:0]       S_AXI_RDATA,
  output logic [1:0]        S_AXI_RRESP,
  output logic              S_AXI_RLAST,
  output logic [USER_W-1:0] S_AXI_RUSER,
  output logic              S_AXI_RVALID,
  input  logic              S_AXI_RREADY,
  input  logic              stall_in,
  output logic [CNT_W-1:0]  beat_cnt_out,
  output logic [7:0]        err_cnt_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [7:0]        LAT_INIT    = 8'(RD_LATENCY - 1);
  localparam logic [1:0]        RESP_OKAY   = 2'b00;
  localparam logic [1:0]        RESP_SLVERR = 2'b10;

  function automatic logic [63:0] beat_data(input logic [ADDR_W-1:0] a, input logic err);
    if (err) begin
      beat_data = 64'd0;
    end else begin
      beat_data = {~a[31:0], a[31:0]};
    end
  endfunction

  // Address of the beat following a; the INCR alignment is a no-op after the first beat.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [1:0]        burst,
                                                  input logic [2:0]        size,
                                                  input logic [7:0]        len);
    logic [ADDR_W-1:0] incr;
    logic [ADDR_W-1:0] mask;
    logic [8:0]        beats;
    beats = {1'b0, len} + 9'd1;
    incr  = ADDR_ONE << size;
    mask  = ({{(ADDR_W-9){1'b0}}, beats} * incr) - ADDR_ONE;
    case (burst)
      2'b00:   next_addr = a;
      2'b01:   next_addr = (a & ~(incr - ADDR_ONE)) + incr;
      2'b10:   next_addr = (a & ~mask) | ((a + incr) & mask);
      default: next_addr = a;
    endcase
  endfunction

  state_t              state_r, state_s;
  logic                arready_r, arready_s;
  logic                rvalid_r, rvalid_s;
  logic                rlast_r, rlast_s;
  logic [63:0]         rdata_r, rdata_s;
  logic [1:0]          rresp_r, rresp_s;
  logic [ID_W-1:0]     rid_r, rid_s;
  logic [USER_W-1:0]   ruser_r, ruser_s;
  logic [ID_W-1:0]     id_r, id_s;
  logic [USER_W-1:0]   user_r, user_s;
  logic [ADDR_W-1:0]   addr_r, addr_s;
  logic [7:0]          len_r, len_s;
  logic [2:0]          size_r, size_s;
  logic [1:0]          burst_r, burst_s;
  logic                err_r, err_s;
  logic [7:0]          idx_r, idx_s;
  logic [7:0]          lat_r, lat_s;
  logic [CNT_W-1:0]    beat_cnt_r, beat_cnt_s;
  logic [7:0]          err_cnt_r, err_cnt_s;
  logic                ar_err_s;

  // Request legality check on the live AR channel.
  always_comb begin
    ar_err_s = 1'b0;
    if (S_AXI_ARBURST == 2'b11 || S_AXI_ARSIZE > 3'd3) begin
      ar_err_s = 1'b1;
    end else if (S_AXI_ARBURST == 2'b10) begin
      ar_err_s = !(S_AXI_ARLEN == 8'd1 || S_AXI_ARLEN == 8'd3 ||
                   S_AXI_ARLEN == 8'd7 || S_AXI_ARLEN == 8'd15);
    end else begin
      ar_err_s = 1'b0;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s    = state_r;
    arready_s  = arready_r;
    rvalid_s   = rvalid_r;
    rlast_s    = rlast_r;
    rdata_s    = rdata_r;
    rresp_s    = rresp_r;
    rid_s      = rid_r;
    ruser_s    = ruser_r;
    id_s       = id_r;
    user_s     = user_r;
    addr_s     = addr_r;
    len_s      = len_r;
    size_s     = size_r;
    burst_s    = burst_r;
    err_s      = err_r;
    idx_s      = idx_r;
    lat_s      = lat_r;
    beat_cnt_s = beat_cnt_r;
    err_cnt_s  = err_cnt_r;

    case (state_r)
      ST_IDLE: begin
        arready_s = 1'b1;
        if (S_AXI_ARVALID && arready_r) begin
          arready_s = 1'b0;
          id_s      = S_AXI_ARID;
          user_s    = S_AXI_ARUSER;
          addr_s    = S_AXI_ARADDR;
          len_s     = S_AXI_ARLEN;
          size_s    = S_AXI_ARSIZE;
          burst_s   = S_AXI_ARBURST;
          err_s     = ar_err_s;
          idx_s     = 8'd0;
          lat_s     = LAT_INIT;
          state_s   = ST_WAIT;
          if (ar_err_s && err_cnt_r != 8'hFF) begin
            err_cnt_s = err_cnt_r + 8'd1;
          end else begin
            err_cnt_s = err_cnt_r;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (lat_r != 8'd0) begin
          lat_s = lat_r - 8'd1;
        end else if (!stall_in) begin
          rvalid_s = 1'b1;
          rdata_s  = beat_data(addr_r, err_r);
          rresp_s  = err_r ? RESP_SLVERR : RESP_OKAY;
          rlast_s  = (len_r == 8'd0);
          rid_s    = id_r;
          ruser_s  = user_r;
          state_s  = ST_BURST;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_BURST: begin
        if (rvalid_r && S_AXI_RREADY) begin
          if (rlast_r) begin
            rvalid_s  = 1'b0;
            rlast_s   = 1'b0;
            arready_s = 1'b1;
            state_s   = ST_IDLE;
          end else begin
            addr_s = next_addr(addr_r, burst_r, size_r, len_r);
            idx_s  = idx_r + 8'd1;
            if (stall_in) begin
              rvalid_s = 1'b0;
            end else begin
              rvalid_s = 1'b1;
              rdata_s  = beat_data(addr_s, err_r);
              rlast_s  = (idx_s == len_r);
            end
          end
        end else if (!rvalid_r && !stall_in) begin
          // Resume after a stall with the beat already addressed by addr_r.
          rvalid_s = 1'b1;
          rdata_s  = beat_data(addr_r, err_r);
          rlast_s  = (idx_r == len_r);
        end else begin
          state_s = ST_BURST;
        end
      end
      default: begin
        state_s   = ST_IDLE;
        arready_s = 1'b0;
        rvalid_s  = 1'b0;
        rlast_s   = 1'b0;
      end
    endcase

    if (rvalid_r && S_AXI_RREADY && beat_cnt_r != CNT_MAX) begin
      beat_cnt_s = beat_cnt_r + CNT_ONE;
    end else begin
      beat_cnt_s = beat_cnt_r;
    end
  end

  // State and output registers.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_r    <= ST_IDLE;
      arready_r  <= 1'b0;
      rvalid_r   <= 1'b0;
      rlast_r    <= 1'b0;
      rdata_r    <= 64'd0;
      rresp_r    <= 2'b00;
      rid_r      <= {ID_W{1'b0}};
      ruser_r    <= {USER_W{1'b0}};
      id_r       <= {ID_W{1'b0}};
      user_r     <= {USER_W{1'b0}};
      addr_r     <= {ADDR_W{1'b0}};
      len_r      <= 8'd0;
      size_r     <= 3'd0;
      burst_r    <= 2'b00;
      err_r      <= 1'b0;
      idx_r      <= 8'd0;
      lat_r      <= 8'd0;
      beat_cnt_r <= {CNT_W{1'b0}};
      err_cnt_r  <= 8'd0;
    end else begin
      state_r    <= state_s;
      arready_r  <= arready_s;
      rvalid_r   <= rvalid_s;
      rlast_r    <= rlast_s;
      rdata_r    <= rdata_s;
      rresp_r    <= rresp_s;
      rid_r      <= rid_s;
      ruser_r    <= ruser_s;
      id_r       <= id_s;
      user_r     <= user_s;
      addr_r     <= addr_s;
      len_r      <= len_s;
      size_r     <= size_s;
      burst_r    <= burst_s;
      err_r      <= err_s;
      idx_r      <= idx_s;
      lat_r      <= lat_s;
      beat_cnt_r <= beat_cnt_s;
      err_cnt_r  <= err_cnt_s;
    end
  end

  assign S_AXI_ARREADY = arready_r;
  assign S_AXI_RVALID  = rvalid_r;
  assign S_AXI_RLAST   = rlast_r;
  assign S_AXI_RDATA   = rdata_r;
  assign S_AXI_RRESP   = rresp_r;
  assign S_AXI_RID     = rid_r;
  assign S_AXI_RUSER   = ruser_r;
  assign beat_cnt_out  = beat_cnt_r;
  assign err_cnt_out   = err_cnt_r;

endmodule

// File: tb/tb_axi_rd_resp_slave.sv
// Self-checking bench for axi_rd_resp_slave: table of directed bursts, hand-written
// stall/reset sequences and randomized bursts against a per-beat reference model.
module tb_axi_rd_resp_slave;

  localparam int LAT = 4;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [0:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [7:0]  aruser;
  logic        arvalid;
  logic        arready;
  logic [0:0]  rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [7:0]  ruser;
  logic        rvalid;
  logic        rready;
  logic        stall;
  logic [15:0] beat_cnt;
  logic [7:0]  err_cnt;

  always #5 ACLK = ~ACLK;

  axi_rd_resp_slave #(
    .ID_W(1), .ADDR_W(32), .USER_W(8), .RD_LATENCY(LAT), .CNT_W(16)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
    .S_AXI_ARSIZE(arsize), .S_AXI_ARBURST(arburst), .S_AXI_ARUSER(aruser),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
    .S_AXI_RUSER(ruser), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .stall_in(stall), .beat_cnt_out(beat_cnt), .err_cnt_out(err_cnt)
  );

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [0:0]  id;
    logic [7:0]  user;
  } beat_t;

  typedef struct {
    logic [0:0]       id;
    logic [31:0]      addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic [7:0]       user;
    logic [3:0][31:0] exp_a;
    logic [1:0]       exp_resp;
    int               rr_mode;
  } vec_t;

  beat_t exp_q[$];
  vec_t  tbl[10];
  int    n_vec = 0;
  int    n_mis = 0;
  int    mdl_beats = 0;
  int    mdl_errs = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [0:0] id, input logic [31:0] addr,
                               input logic [7:0] len, input logic [2:0] size,
                               input logic [1:0] burst, input logic [7:0] user,
                               input logic [31:0] a0, input logic [31:0] a1,
                               input logic [31:0] a2, input logic [31:0] a3,
                               input logic [1:0] resp, input int rr);
    vec_t v;
    v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst; v.user = user;
    v.exp_a[0] = a0; v.exp_a[1] = a1; v.exp_a[2] = a2; v.exp_a[3] = a3;
    v.exp_resp = resp; v.rr_mode = rr;
    return v;
  endfunction

  function automatic bit is_err(input logic [7:0] len, input logic [2:0] size,
                                input logic [1:0] burst);
    return (burst == 2'b11) || (size > 3'd3) ||
           (burst == 2'b10 && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
  endfunction

  // Beat i address computed directly from the start address (no iteration).
  function automatic logic [31:0] model_addr(input logic [31:0] addr, input logic [7:0] len,
                                             input logic [2:0] size, input logic [1:0] burst,
                                             input int i);
    longint unsigned incr, cont, base, a, start;
    start = addr;
    incr  = 64'd1 << size;
    case (burst)
      2'b01: a = (i == 0) ? start : (start / incr) * incr + longint'(i) * incr;
      2'b10: begin
        cont = (longint'(len) + 1) * incr;
        base = (start / cont) * cont;
        a    = base + ((start - base + longint'(i) * incr) % cont);
      end
      default: a = start;
    endcase
    return a[31:0];
  endfunction

  function automatic void push_model(input logic [0:0] id, input logic [31:0] addr,
                                     input logic [7:0] len, input logic [2:0] size,
                                     input logic [1:0] burst, input logic [7:0] user);
    beat_t       b;
    logic [31:0] a;
    bit          e;
    e = is_err(len, size, burst);
    for (int i = 0; i <= int'(len); i++) begin
      a      = model_addr(addr, len, size, burst, i);
      b.data = e ? 64'd0 : {~a, a};
      b.resp = e ? 2'b10 : 2'b00;
      b.last = (i == int'(len));
      b.id   = id;
      b.user = user;
      exp_q.push_back(b);
    end
  endfunction

  task automatic do_ar(input logic [0:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst, input logic [7:0] user,
                       output bit hs);
    @(posedge ACLK); #1;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; aruser = user;
    arvalid = 1'b1; stall = 1'b0; rready = 1'b1;
    hs = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge ACLK);
      if (arready) hs = 1'b1;
      @(posedge ACLK); #1;
      if (hs) break;
    end
    arvalid = 1'b0;
    chk("ar_handshake", 128'(hs), 128'(1));
  endtask

  // rr_mode: 0 always ready, 1 pattern 1,0,0 repeating, 2 random.
  // st_mode: 0 none, 1 random, 2 held high for three cycles mid-burst.
  task automatic run_burst(input logic [0:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic [7:0] user,
                           input int rr_mode, input int st_mode, input bit exp_err);
    bit          hs, seen, first, pv, pr, ps;
    int          lat, cyc;
    logic [75:0] cur, held;
    beat_t       eb;
    do_ar(id, addr, len, size, burst, user, hs);
    if (!hs) begin
      exp_q.delete();
      return;
    end
    if (exp_err && mdl_errs < 255) mdl_errs++;
    seen = 1'b0; lat = 0;
    for (int k = 0; k <= 300; k++) begin
      @(negedge ACLK);
      if (k == 0) chk("arready_drop", 128'(arready), 128'(0));
      if (rvalid) begin
        seen = 1'b1; lat = k;
        break;
      end
      @(posedge ACLK); #1;
    end
    if (!seen) begin
      chk("first_rvalid_timeout", 128'(seen), 128'(1));
      exp_q.delete();
      return;
    end
    chk("first_rvalid_latency", 128'(lat), 128'(LAT));
    cyc = 0; first = 1'b1; pv = 1'b0; pr = 1'b0; ps = 1'b0; held = '0;
    while (exp_q.size() > 0 && cyc < 600) begin
      cur = {rdata, rresp, rlast, rid, ruser};
      if (!first) begin
        if (pv && !pr) begin
          chk("hold_rvalid", 128'(rvalid), 128'(1));
          chk("hold_payload", 128'(cur), 128'(held));
        end else begin
          chk("rvalid_after_beat", 128'(rvalid), 128'(!ps));
        end
      end
      chk("arready_busy", 128'(arready), 128'(0));
      if (rvalid && rready) begin
        eb = exp_q.pop_front();
        chk("beat", 128'(cur), 128'(eb));
        mdl_beats++;
      end
      pv = rvalid; pr = rready; ps = stall; held = cur; first = 1'b0;
      @(posedge ACLK); #1;
      cyc++;
      case (rr_mode)
        1:       rready = (cyc % 3 == 0);
        2:       rready = ($urandom_range(0, 3) != 0);
        default: rready = 1'b1;
      endcase
      case (st_mode)
        1:       stall = ($urandom_range(0, 3) == 0);
        2:       stall = (cyc >= 2 && cyc <= 4);
        default: stall = 1'b0;
      endcase
      @(negedge ACLK);
    end
    if (exp_q.size() != 0) begin
      chk("burst_timeout", 128'(exp_q.size()), 128'(0));
      exp_q.delete();
    end
    chk("end_rvalid", 128'(rvalid), 128'(0));
    chk("end_rlast", 128'(rlast), 128'(0));
    chk("end_arready", 128'(arready), 128'(1));
    chk("beat_cnt", 128'(beat_cnt), 128'(mdl_beats));
    chk("err_cnt", 128'(err_cnt), 128'(mdl_errs));
  endtask

  bit          hs_m, seen_m;
  beat_t       tb_b;
  logic [31:0] ta;
  logic [0:0]  r_id;
  logic [31:0] r_addr;
  logic [7:0]  r_len;
  logic [2:0]  r_size;
  logic [1:0]  r_burst;
  logic [7:0]  r_user;
  int          sel;

  initial begin
    tbl[0] = mkv(1'b1, 32'h1000, 8'd3, 3'd3, 2'b01, 8'h5A,
                 32'h1000, 32'h1008, 32'h1010, 32'h1018, 2'b00, 0);
    tbl[1] = mkv(1'b0, 32'h1038, 8'd3, 3'd3, 2'b10, 8'h11,
                 32'h1038, 32'h1020, 32'h1028, 32'h1030, 2'b00, 0);
    tbl[2] = mkv(1'b1, 32'h0020, 8'd2, 3'd3, 2'b00, 8'h22,
                 32'h0020, 32'h0020, 32'h0020, 32'h0, 2'b00, 1);
    tbl[3] = mkv(1'b0, 32'h0300, 8'd1, 3'd3, 2'b11, 8'h33,
                 32'h0, 32'h0, 32'h0, 32'h0, 2'b10, 0);
    tbl[4] = mkv(1'b1, 32'h1003, 8'd2, 3'd2, 2'b01, 8'h44,
                 32'h1003, 32'h1004, 32'h1008, 32'h0, 2'b00, 0);
    tbl[5] = mkv(1'b0, 32'hFFFF_FFF8, 8'd1, 3'd3, 2'b01, 8'h55,
                 32'hFFFF_FFF8, 32'h0000_0000, 32'h0, 32'h0, 2'b00, 0);
    tbl[6] = mkv(1'b1, 32'h0040, 8'd0, 3'd0, 2'b01, 8'h66,
                 32'h0040, 32'h0, 32'h0, 32'h0, 2'b00, 0);
    tbl[7] = mkv(1'b0, 32'h0200, 8'd2, 3'd2, 2'b10, 8'h77,
                 32'h0, 32'h0, 32'h0, 32'h0, 2'b10, 0);
    tbl[8] = mkv(1'b1, 32'h0500, 8'd1, 3'd4, 2'b01, 8'h88,
                 32'h0, 32'h0, 32'h0, 32'h0, 2'b10, 0);
    tbl[9] = mkv(1'b0, 32'h0104, 8'd1, 3'd2, 2'b10, 8'h99,
                 32'h0104, 32'h0100, 32'h0, 32'h0, 2'b00, 1);

    ARESETN = 1'b0; arvalid = 1'b0; rready = 1'b0; stall = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; aruser = '0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("reset_outputs",
        128'({arready, rvalid, rlast, rdata, rresp, rid, ruser, beat_cnt, err_cnt}), 128'(0));
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    @(negedge ACLK);
    chk("arready_before_first_edge", 128'(arready), 128'(0));
    @(negedge ACLK);
    chk("arready_after_release", 128'(arready), 128'(1));

    for (int i = 0; i < 10; i++) begin
      for (int b = 0; b <= int'(tbl[i].len); b++) begin
        ta        = tbl[i].exp_a[b];
        tb_b.data = (tbl[i].exp_resp == 2'b10) ? 64'd0 : {~ta, ta};
        tb_b.resp = tbl[i].exp_resp;
        tb_b.last = (b == int'(tbl[i].len));
        tb_b.id   = tbl[i].id;
        tb_b.user = tbl[i].user;
        exp_q.push_back(tb_b);
      end
      run_burst(tbl[i].id, tbl[i].addr, tbl[i].len, tbl[i].size, tbl[i].burst, tbl[i].user,
                tbl[i].rr_mode, 0, tbl[i].exp_resp == 2'b10);
    end

    push_model(1'b1, 32'h2000, 8'd5, 3'd3, 2'b01, 8'hC3);
    run_burst(1'b1, 32'h2000, 8'd5, 3'd3, 2'b01, 8'hC3, 0, 2, 1'b0);

    // Reset in the middle of a burst, then confirm nothing is replayed.
    do_ar(1'b1, 32'h3000, 8'd7, 3'd3, 2'b01, 8'h5C, hs_m);
    if (hs_m) begin
      seen_m = 1'b0;
      for (int k = 0; k < 50; k++) begin
        @(negedge ACLK);
        if (rvalid) begin
          seen_m = 1'b1;
          break;
        end
        @(posedge ACLK); #1;
      end
      chk("rst_seq_rvalid_seen", 128'(seen_m), 128'(1));
      @(posedge ACLK); #1;
      @(posedge ACLK); #1;
      ARESETN = 1'b0;
      @(posedge ACLK); #1;
      @(negedge ACLK);
      chk("midburst_reset_state",
          128'({rvalid, arready, rlast, rdata, beat_cnt, err_cnt}), 128'(0));
      mdl_beats = 0; mdl_errs = 0;
      @(posedge ACLK); #1;
      ARESETN = 1'b1;
      for (int k = 0; k < 4; k++) begin
        @(negedge ACLK);
        chk("no_replay_rvalid", 128'(rvalid), 128'(0));
        @(posedge ACLK); #1;
      end
      @(negedge ACLK);
      chk("arready_after_midburst_reset", 128'(arready), 128'(1));
    end
    push_model(1'b0, 32'h4008, 8'd3, 3'd3, 2'b10, 8'hE1);
    run_burst(1'b0, 32'h4008, 8'd3, 3'd3, 2'b10, 8'hE1, 2, 1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 2 || sel == 9) r_burst = 2'b01;
      else if (sel <= 4) r_burst = 2'b00;
      else if (sel <= 7) r_burst = 2'b10;
      else r_burst = 2'b11;
      if (r_burst == 2'b10 && $urandom_range(0, 4) != 0) begin
        case ($urandom_range(0, 3))
          0:       r_len = 8'd1;
          1:       r_len = 8'd3;
          2:       r_len = 8'd7;
          default: r_len = 8'd15;
        endcase
      end else begin
        r_len = 8'($urandom_range(0, 15));
      end
      r_size = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      r_addr = $urandom;
      r_id   = 1'($urandom_range(0, 1));
      r_user = 8'($urandom_range(0, 255));
      push_model(r_id, r_addr, r_len, r_size, r_burst, r_user);
      run_burst(r_id, r_addr, r_len, r_size, r_burst, r_user, 2, 1,
                is_err(r_len, r_size, r_burst));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/axi_rd_resp_slave.md
Name: axi_rd_resp_slave

Overview:
- Synthesizable AXI4 read-channel slave that answers the AR requests issued by the DDR memory-agent master.
- Replaces the one-line RVALID echo stub with protocol-correct bursts: single-outstanding AR acceptance, programmable first-beat latency, INCR/FIXED/WRAP address generation, RLAST, RID echo and error responses.
- Used in simulation and on-board loopback as the DDR stand-in.
- Read data is a deterministic function of the beat address so the master's output can be checked.

Parameters:
- ID_W, 1, width of ARID/RID.
- ADDR_W, 32, address width (must be >= 32).
- USER_W, 8, width of ARUSER/RUSER.
- RD_LATENCY, 4, cycles from AR handshake edge to first RVALID edge (legal 1..255).
- CNT_W, 16, width of beat statistics counter.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  reset; synchronous, active-low; clock ACLK.
- S_AXI_ARID  in  ID_W  read ID.
- S_AXI_ARADDR  in  ADDR_W  start address.
- S_AXI_ARLEN  in  8  beats-1.
- S_AXI_ARSIZE  in  3  log2 bytes per beat.
- S_AXI_ARBURST  in  2  burst type.
- S_AXI_ARUSER  in  USER_W  user sideband.
- S_AXI_ARVALID  in  1  AR valid.
- S_AXI_ARREADY  out  1  AR ready.
- S_AXI_RID  out  ID_W  echoed ARID.
- S_AXI_RDATA  out  64  beat data.
- S_AXI_RRESP  out  2  response.
- S_AXI_RLAST  out  1  final beat.
- S_AXI_RUSER  out  USER_W  echoed ARUSER.
- S_AXI_RVALID  out  1  R valid.
- S_AXI_RREADY  in  1  R ready.
- stall_in  in  1  test hook; while 1, no new beat is presented.
- beat_cnt_out  out  CNT_W  accepted R beats, saturating.
- err_cnt_out  out  8  SLVERR bursts, saturating.

Behaviour:
- Reset values: ARREADY=0, RVALID=0, RLAST=0, RDATA=0, RRESP=0, RID=0, RUSER=0, counters 0, FSM=IDLE.
- Reset mid-burst: the whole burst is abandoned; outputs take reset values at the first edge with ARESETN=0. No beat is replayed after release.
- FSM IDLE:
  - ARREADY=1 (registered; first high the cycle after reset release).
  - On an ARVALID&ARREADY edge, capture ID/ADDR/LEN/SIZE/BURST/USER, load the latency counter with RD_LATENCY-1, drop ARREADY, go to WAIT.
- FSM WAIT:
  - Counter decrements each cycle.
  - At zero with stall_in=0, present beat 0 (RVALID=1) and go to BURST.
  - With stall_in=1 at zero, hold in WAIT.
  - First RVALID is visible exactly RD_LATENCY cycles after the AR handshake edge.
- FSM BURST:
  - Beat accepted on RVALID&RREADY.
  - If the accepted beat was last: RVALID=0, RLAST=0, go to IDLE (ARREADY=1 next cycle).
  - Otherwise advance the beat address. If stall_in=1, drop RVALID until stall_in=0. Else present the next beat on the next cycle, so full throughput is 1 beat/cycle.
  - While RVALID=1 and RREADY=0, RDATA, RRESP, RLAST, RID and RUSER hold stable. stall_in never withdraws a presented beat.
- RLAST=1 only on beat index ARLEN; ARLEN=0 gives a single beat with RLAST=1.
- Address generation (beat address A, increment 2^ARSIZE):
  - FIXED (00): A constant.
  - INCR (01): A+=incr. Start address aligned down to incr for beats >=1. Wraps modulo 2^ADDR_W.
  - WRAP (10): container = (ARLEN+1)*incr. Next A = (A & ~(container-1)) | ((A+incr) & (container-1)).
- RDATA = {~A[31:0], A[31:0]} with RRESP=OKAY(00).
- Error: ARBURST=11, ARSIZE>3, or WRAP with ARLEN not in {1,3,7,15}.
  - Full ARLEN+1 beats are still returned, each with RRESP=SLVERR(10) and RDATA=0. RLAST is normal.
  - err_cnt_out increments once at the AR handshake.
- beat_cnt_out increments per accepted beat; saturates at all-ones. err_cnt_out saturates at 255.
- ARVALID arriving during WAIT/BURST is ignored (ARREADY=0). The request must be held by the master per AXI.

Test Plan:
- Reset, then AR INCR ADDR=0x1000 LEN=3 SIZE=3 ID=1, RREADY=1 -> RVALID rises 4 cycles after handshake; 4 consecutive beats with RDATA low words 0x1000/0x1008/0x1010/0x1018, high words inverted; RLAST on beat 3; RID=1; beat_cnt_out=4.
- WRAP ADDR=0x1038 LEN=3 SIZE=3 -> beat addresses 0x1038,0x1020,0x1028,0x1030; RLAST on the 4th beat.
- FIXED LEN=2 ADDR=0x20 with RREADY toggling 1,0,0,1,... -> RDATA low word 0x20 on all 3 beats; outputs stable while RREADY=0; no beat dropped or duplicated.
- ARBURST=11 LEN=1 -> 2 beats RRESP=10, RDATA=0, RLAST on beat 1; err_cnt_out=1; next legal AR accepted with OKAY.
- stall_in=1 for 3 cycles mid-burst -> RVALID low during the stall; burst resumes at the correct next address. ARESETN=0 asserted mid-burst -> RVALID=0 and ARREADY=0 at the next edge; after release, ARREADY=1 and a new burst runs correctly.
